// File: rtl/io_bus_bridge.sv
// io_bus_bridge
//   Sits between the cpu external memory bus and the RAM / UART / system
//   registers. Each cycle the bus carries one byte access; it is decoded to
//   either the 128 KB RAM or the I/O space (mem_a[17:16] == 2'b11). Read data
//   is presented on mem_din one cycle after the request.
//
//   I/O map (offset = mem_a[15:0] inside the I/O space):
//     0x0000 read  : UART RX byte (pops the UART), 0x00 if none available
//     0x0000 write : push non-zero byte into the TX FIFO
//     0x0004 read  : snapshot the cycle counter, return byte 0
//     0x0005-7 read: bytes 1..3 of the same snapshot
//     0x0004 write : set program_stop and push 0x00 into the TX FIFO
//
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   rdy_in             cpu pause; low = no bus access, counter frozen
//   mem_a/mem_dout/mem_wr   cpu bus request
//   mem_din            read data (one cycle after the request)
//   io_buffer_full     TX FIFO near-full back-pressure to the cpu
//   ram_*              RAM port (ram_rdata has 1-cycle latency)
//   tx_valid/tx_data/tx_ready   TX FIFO head towards the UART
//   rx_valid/rx_data/rx_pop     UART RX byte and its consume pulse
//   program_stop       sticky stop flag
//   tx_overflow        sticky: a push hit a full FIFO
module io_bus_bridge #(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int FULL_MARGIN   = 2,
    parameter int RAM_ADDR_WID  = 17
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [31:0]             mem_a,
    input  logic [7:0]              mem_dout,
    input  logic                    mem_wr,
    output logic [7:0]              mem_din,
    output logic                    io_buffer_full,
    output logic                    ram_en,
    output logic                    ram_wr,
    output logic [RAM_ADDR_WID-1:0] ram_a,
    output logic [7:0]              ram_wdata,
    input  logic [7:0]              ram_rdata,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_pop,
    output logic                    program_stop,
    output logic                    tx_overflow
);

    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int PW    = TX_DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] MARGIN_P = PW'(FULL_MARGIN);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_RX,
        SEL_CNT0,
        SEL_CNT1,
        SEL_CNT2,
        SEL_CNT3,
        SEL_ZERO
    } rd_sel_t;

    // ---- stage p0: request decode (combinational, same cycle as the bus) ----
    logic        acc_p0;
    logic        rd_p0;
    logic        wr_p0;
    logic        is_io_p0;
    logic [15:0] io_off_p0;
    logic        io_rx_p0;
    logic        io_cnt_p0;
    logic        io_stop_p0;
    logic        push_req_p0;
    logic [7:0]  push_data_p0;

    // Upper address bits are outside both the RAM and the I/O decode.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_a[31:18];

    assign acc_p0     = rdy_in && !rst_in;
    assign rd_p0      = acc_p0 && !mem_wr;
    assign wr_p0      = acc_p0 && mem_wr;
    assign is_io_p0   = (mem_a[17:16] == 2'b11);
    assign io_off_p0  = mem_a[15:0];
    assign io_rx_p0   = is_io_p0 && (io_off_p0 == 16'h0000);
    assign io_stop_p0 = is_io_p0 && (io_off_p0 == 16'h0004);
    assign io_cnt_p0  = is_io_p0 && (io_off_p0[15:2] == 14'h0001);

    assign ram_en    = acc_p0 && !is_io_p0;
    assign ram_wr    = mem_wr;
    assign ram_a     = mem_a[RAM_ADDR_WID-1:0];
    assign ram_wdata = mem_dout;

    // The RX byte is consumed on the same edge it is latched.
    assign rx_pop = rd_p0 && io_rx_p0 && rx_valid;

    // Zero bytes written to the data port are dropped; the stop write always
    // pushes a 0x00 terminator.
    assign push_req_p0  = wr_p0 && ((io_rx_p0 && (mem_dout != 8'h00)) || io_stop_p0);
    assign push_data_p0 = io_stop_p0 ? 8'h00 : mem_dout;

    rd_sel_t rd_sel;
    rd_sel_t rd_sel_nxt;

    always_comb begin
        rd_sel_nxt = rd_sel;
        if (rd_p0) begin
            if (!is_io_p0) begin
                rd_sel_nxt = SEL_RAM;
            end else if (io_rx_p0) begin
                rd_sel_nxt = rx_valid ? SEL_RX : SEL_ZERO;
            end else if (io_cnt_p0) begin
                case (io_off_p0[1:0])
                    2'd0:    rd_sel_nxt = SEL_CNT0;
                    2'd1:    rd_sel_nxt = SEL_CNT1;
                    2'd2:    rd_sel_nxt = SEL_CNT2;
                    default: rd_sel_nxt = SEL_CNT3;
                endcase
            end else begin
                rd_sel_nxt = SEL_ZERO;
            end
        end
    end

    // ---- TX FIFO bookkeeping ----
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] count;
    logic [PW-1:0] count_nxt;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;

    assign count     = wptr - rptr;
    assign fifo_full = (count == DEPTH_P);
    assign tx_valid  = (count != '0);
    assign tx_data   = tx_mem[rptr[TX_DEPTH_LOG2-1:0]];
    assign pop       = tx_valid && tx_ready;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push_req_p0 && (!fifo_full || pop);
    assign count_nxt = count + PW'(push_ok) - PW'(pop);

    // ---- stage p1: registered state ----
    logic [31:0] cycle_cnt;
    logic [31:0] snapshot;
    logic [7:0]  rx_byte_p1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_sel         <= SEL_NONE;
            wptr           <= '0;
            rptr           <= '0;
            cycle_cnt      <= '0;
            snapshot       <= '0;
            io_buffer_full <= 1'b0;
            program_stop   <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            rd_sel <= rd_sel_nxt;
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (push_req_p0 && !push_ok) begin
                tx_overflow <= 1'b1;
            end
            if (wr_p0 && io_stop_p0) begin
                program_stop <= 1'b1;
            end
            // Registered on the post-update occupancy; the margin absorbs
            // stores already in flight when the cpu sees the flag.
            io_buffer_full <= ((DEPTH_P - count_nxt) <= MARGIN_P);
            if (rdy_in) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            // Only byte 0 refreshes the snapshot so a 4-byte read is coherent.
            if (rd_p0 && io_cnt_p0 && (io_off_p0[1:0] == 2'd0)) begin
                snapshot <= cycle_cnt;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            tx_mem[wptr[TX_DEPTH_LOG2-1:0]] <= push_data_p0;
        end
        if (rx_pop) begin
            rx_byte_p1 <= rx_data;
        end
    end

    // ---- stage p1: read data return ----
    always_comb begin
        case (rd_sel)
            SEL_RAM:  mem_din = ram_rdata;
            SEL_RX:   mem_din = rx_byte_p1;
            SEL_CNT0: mem_din = snapshot[7:0];
            SEL_CNT1: mem_din = snapshot[15:8];
            SEL_CNT2: mem_din = snapshot[23:16];
            SEL_CNT3: mem_din = snapshot[31:24];
            default:  mem_din = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_io_bus_bridge.sv
module tb_io_bus_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        ram_en;
    logic        ram_wr;
    logic [16:0] ram_a;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        program_stop;
    logic        tx_overflow;

    io_bus_bridge #(.TX_DEPTH_LOG2(4), .FULL_MARGIN(2), .RAM_ADDR_WID(17)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
        .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_q[$];
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic [7:0]  m_din;
    bit          m_sel_ram;
    bit          m_stop;
    bit          m_ovf;
    bit          m_nf;
    bit          m_io;
    bit          m_push;
    logic [7:0]  m_pd;
    logic [15:0] m_off;

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_q.delete();
            m_cnt = 0; m_snap = 0; m_din = 0; m_sel_ram = 0;
            m_stop = 0; m_ovf = 0; m_nf = 0;
        end else begin
            if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
            if (rdy_in) begin
                m_io  = (mem_a[17:16] == 2'b11);
                m_off = mem_a[15:0];
                if (!mem_wr) begin
                    m_sel_ram = !m_io;
                    m_din = 8'h00;
                    if (m_io && m_off == 16'h0000 && rx_valid) m_din = rx_data;
                    if (m_io && m_off == 16'h0004) begin
                        m_din  = m_cnt[7:0];
                        m_snap = m_cnt;
                    end
                    if (m_io && m_off >= 16'h0005 && m_off <= 16'h0007)
                        m_din = m_snap[8*(m_off-16'h0004) +: 8];
                end else begin
                    m_push = 0;
                    m_pd = 0;
                    if (m_io && m_off == 16'h0000 && mem_dout != 0) begin
                        m_push = 1; m_pd = mem_dout;
                    end
                    if (m_io && m_off == 16'h0004) begin
                        m_push = 1; m_pd = 8'h00; m_stop = 1;
                    end
                    if (m_push) begin
                        if (m_q.size() < 16) m_q.push_back(m_pd);
                        else m_ovf = 1;
                    end
                end
                m_cnt = m_cnt + 1;
            end
            m_nf = (16 - m_q.size()) <= 2;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_in) begin
        if (armed) begin
            chk("mem_din", {24'h0, mem_din}, {24'h0, m_sel_ram ? ram_rdata : m_din});
            chk("ram_en", {31'h0, ram_en},
                {31'h0, !rst_in && rdy_in && (mem_a[17:16] != 2'b11)});
            chk("rx_pop", {31'h0, rx_pop},
                {31'h0, !rst_in && rdy_in && !mem_wr && mem_a[17:16] == 2'b11
                        && mem_a[15:0] == 16'h0 && rx_valid});
            chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
            if (m_q.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
            chk("io_buffer_full", {31'h0, io_buffer_full}, {31'h0, m_nf});
            chk("program_stop", {31'h0, program_stop}, {31'h0, m_stop});
            chk("tx_overflow", {31'h0, tx_overflow}, {31'h0, m_ovf});
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] exp_cnt [4];
    logic [7:0] t2_data [3];

    initial begin
        exp_cnt = '{8'h05, 8'h00, 8'h00, 8'h00};
        t2_data = '{8'h41, 8'h00, 8'h42};
        rst_in = 1; rdy_in = 0; mem_a = 0; mem_dout = 0; mem_wr = 0;
        ram_rdata = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
        tick();
        armed = 1'b1;
        chk("rst_mem_din", {24'h0, mem_din}, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        chk("rst_stop", {31'h0, program_stop}, 32'h0);
        chk("rst_ovf", {31'h0, tx_overflow}, 32'h0);

        // Counter snapshot after 5 running cycles
        rst_in = 0; rdy_in = 1;
        repeat (5) tick();
        for (int k = 0; k < 4; k++) begin
            mem_a = 32'h30004 + k;
            tick();
            chk("cnt_byte", {24'h0, mem_din}, {24'h0, exp_cnt[k]});
        end

        // TX writes with zero filtering
        mem_wr = 1; mem_a = 32'h30000;
        for (int k = 0; k < 3; k++) begin
            mem_dout = t2_data[k];
            tick();
        end
        mem_wr = 0; mem_a = 0;
        chk("tx_head0", {24'h0, tx_data}, 32'h41);
        chk("tx_valid2", {31'h0, tx_valid}, 32'h1);
        tx_ready = 1;
        tick();
        chk("tx_head1", {24'h0, tx_data}, 32'h42);
        tick();
        chk("tx_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 0;

        // Fill to near-full, full, overflow
        mem_wr = 1; mem_a = 32'h30000; mem_dout = 8'h55;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 13) chk("nf_at13", {31'h0, io_buffer_full}, 32'h0);
            if (i == 14) chk("nf_at14", {31'h0, io_buffer_full}, 32'h1);
            if (i == 16) chk("ovf_at16", {31'h0, tx_overflow}, 32'h0);
            if (i == 17) chk("ovf_at17", {31'h0, tx_overflow}, 32'h1);
        end
        mem_wr = 0; mem_a = 0;

        // Mid-operation reset discards the FIFO
        rst_in = 1;
        tick();
        rst_in = 0;
        chk("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst2_ovf", {31'h0, tx_overflow}, 32'h0);

        // Push into full FIFO with simultaneous pop
        mem_wr = 1; mem_a = 32'h30000; mem_dout = 8'h55;
        repeat (16) tick();
        chk("full_nf", {31'h0, io_buffer_full}, 32'h1);
        mem_dout = 8'h77; tx_ready = 1;
        tick();
        chk("pushpop_ovf", {31'h0, tx_overflow}, 32'h0);
        mem_wr = 0; mem_a = 0;
        repeat (15) tick();
        chk("last_out", {24'h0, tx_data}, 32'h77);
        tick();
        chk("drained", {31'h0, tx_valid}, 32'h0);
        tx_ready = 0;

        // RX read with and without a byte
        rx_valid = 1; rx_data = 8'h3A; mem_a = 32'h30000;
        #1 chk("rx_pop_hi", {31'h0, rx_pop}, 32'h1);
        tick();
        rx_valid = 0; mem_a = 0;
        #1 chk("rx_pop_lo", {31'h0, rx_pop}, 32'h0);
        chk("rx_byte", {24'h0, mem_din}, 32'h3A);
        mem_a = 32'h30000;
        #1 chk("rx_nopop", {31'h0, rx_pop}, 32'h0);
        tick();
        chk("rx_none", {24'h0, mem_din}, 32'h0);

        // Stop write, RAM read, pause
        mem_wr = 1; mem_a = 32'h30004; mem_dout = 8'h12;
        tick();
        chk("stop_set", {31'h0, program_stop}, 32'h1);
        chk("stop_byte", {24'h0, tx_data}, 32'h0);
        chk("stop_valid", {31'h0, tx_valid}, 32'h1);
        mem_wr = 0; mem_a = 32'h00100; ram_rdata = 8'hAB;
        tick();
        chk("ram_read", {24'h0, mem_din}, 32'hAB);
        rdy_in = 0; tx_ready = 1; mem_a = 32'h30004;
        repeat (3) tick();
        chk("pause_din", {24'h0, mem_din}, 32'hAB);
        chk("pause_drain", {31'h0, tx_valid}, 32'h0);
        rdy_in = 1; tx_ready = 0;
        for (int k = 0; k < 4; k++) begin
            mem_a = 32'h30004 + k;
            tick();
        end
        mem_a = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
